// File: rtl/lsfr_sync_checker.sv
// PRBS receive checker for the fibonacci_lsfr stream: hunts for a seed, confirms
// LOCK_CNT predictions, then free-runs the predictor and counts mismatches.
module lsfr_sync_checker #(
  parameter int unsigned               BIT_WIDTH = 8,
  parameter logic [BIT_WIDTH-1:0]      TAPS      = 8'hB8,
  parameter int unsigned               LOCK_CNT  = 4,
  parameter int unsigned               LOSS_CNT  = 3,
  parameter int unsigned               CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 din_vld,
  input  logic [BIT_WIDTH-1:0] din_data,
  input  logic                 din_done,
  output logic                 lock,
  output logic                 chk_vld,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam int unsigned LW = $clog2(LOSS_CNT + 1);
  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_TGT = LW'(LOSS_CNT);

  state_t               state, state_nxt;
  logic [BIT_WIDTH-1:0] expected, exp_nxt;
  logic [MW-1:0]        match_cnt, match_nxt;
  logic [LW-1:0]        miss_cnt, miss_nxt;
  logic                 chk_nxt, errp_nxt;

  function automatic logic [BIT_WIDTH-1:0] lfsr_next(input logic [BIT_WIDTH-1:0] s);
    return {s[BIT_WIDTH-2:0], ^(s & TAPS)};
  endfunction

  always_comb begin
    state_nxt = state;
    exp_nxt   = expected;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    chk_nxt   = 1'b0;
    errp_nxt  = 1'b0;
    if (din_vld) begin
      unique case (state)
        HUNT: begin
          if (din_data != '0) begin
            exp_nxt   = lfsr_next(din_data);
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (din_data == expected) begin
            match_nxt = match_cnt + 1'b1;
            exp_nxt   = lfsr_next(din_data);
            if (match_nxt == LOCK_TGT) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
            if (din_data != '0) exp_nxt = lfsr_next(din_data);
            else                state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Predictor free-runs once locked; data never reseeds it here.
          chk_nxt = 1'b1;
          exp_nxt = lfsr_next(expected);
          if (din_data != expected) begin
            errp_nxt = 1'b1;
            miss_nxt = miss_cnt + 1'b1;
            if (miss_nxt == LOSS_TGT) state_nxt = HUNT;
          end else begin
            miss_nxt = '0;
          end
        end
        default: state_nxt = HUNT;
      endcase
      if (din_done) state_nxt = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      expected  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      lock      <= 1'b0;
      chk_vld   <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= exp_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      lock      <= (state_nxt == LOCKED);
      chk_vld   <= chk_nxt;
      err_pulse <= errp_nxt;
    end
  end

  // Saturating counters; clr overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      if (chk_nxt && word_cnt != '1)  word_cnt <= word_cnt + 1'b1;
      if (errp_nxt && err_cnt != '1)  err_cnt  <= err_cnt + 1'b1;
    end
  end

endmodule
